// File: rtl/sub_bytes_serial.sv
`default_nettype none
// ============================================================================
//  Module   : sub_bytes_serial
//  Brief    : AES SubBytes on a 128-bit state, one byte per cycle through a
//             single forward S-box lookup (IDLE -> BUSY x16 -> DONE).
//  Revision : 1.0  initial release
// ============================================================================
module sub_bytes_serial (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Forward S-box, entry i at bits [8i +: 8] (entry 0 leftmost).
    localparam logic [0:2047] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [3:0]   r_cnt;
    logic [0:127] r_work;
    logic [7:0]   w_sbox_in;
    logic [7:0]   w_sbox_out;

    assign w_sbox_in  = r_work[{r_cnt, 3'b000} +: 8];
    assign w_sbox_out = c_sbox[{w_sbox_in, 3'b000} +: 8];
    assign state_out  = r_work;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (r_cnt == 4'd15) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter wraps 15 -> 0 naturally on the final BUSY cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work <= state_in;
                        r_cnt  <= 4'd0;
                    end
                end
                S_BUSY: begin
                    r_work[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
                    r_cnt                        <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub_bytes_serial
//  Brief    : Randomised self-checking bench; reference S-box derived from
//             GF(2^8) inversion plus the AES affine transform.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sub_bytes_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] state_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_sb [256];
    logic [7:0] inv_sb   [256];

    sub_bytes_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    // First k bytes substituted, the rest as captured.
    function automatic logic [0:127] partial(input logic [0:127] s, input int k);
        logic [0:127] r = s;
        for (int i = 0; i < k; i++) r[8*i +: 8] = model_sb[s[8*i +: 8]];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; glitch_at >= 0 pulses in_valid at that BUSY cycle.
    task automatic run_op(input logic [0:127] s, input int hold, input int glitch_at,
                          output logic [0:127] res);
        logic [0:127] held;
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        state_in = s;
        tick();
        in_valid = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 16; c++) begin
            check("busy_flags", {busy, out_valid, in_ready}, 3'b100);
            check("busy_progress", state_out, partial(s, c));
            if (c == glitch_at) begin
                in_valid = 1'b1;
                state_in = ~s;
            end
            tick();
            in_valid = 1'b0;
        end
        check("done_flags", {busy, out_valid, in_ready}, 3'b010);
        check("result", state_out, partial(s, 16));
        held      = state_out;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            tick();
            check("hold_flags", {busy, out_valid, in_ready}, 3'b010);
            check("hold_stable", state_out, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_flags", {busy, out_valid, in_ready}, 3'b001);
        res = held;
    endtask

    initial begin
        logic [0:127] s;
        logic [0:127] r;
        logic [0:127] inv_r;
        logic [0:127] exp_v;
        int           seen;

        for (int i = 0; i < 256; i++) model_sb[i] = sbox_math(8'(i));
        for (int i = 0; i < 256; i++) inv_sb[model_sb[i]] = 8'(i);

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        state_in  = {4{32'hdeadbeef}};
        tick();
        tick();
        check("reset_flags", {busy, out_valid, in_ready}, 3'b001);
        check("reset_work", state_out, 128'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;

        // All-zero state straight after reset release
        run_op(128'h0, 0, -1, r);
        exp_v = {16{8'h63}};
        check("zero_vec", r, exp_v);

        s     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        exp_v = 128'hd42711aee0bf98f1b8b45de51e415230;
        run_op(s, 10, -1, r);
        check("fips_b_round1", r, exp_v);

        s = {$urandom, $urandom, $urandom, $urandom};
        run_op(s, 2, 5, r);
        check("ignored_in_valid", r, partial(s, 16));

        // Every byte value once, checked forward and through the inverse table
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) s[8*j +: 8] = 8'(16*i + j);
            run_op(s, 0, -1, r);
            for (int j = 0; j < 16; j++) inv_r[8*j +: 8] = inv_sb[r[8*j +: 8]];
            check("exhaustive_inv", inv_r, s);
        end

        for (int t = 0; t < 12; t++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_op(s, int'($urandom_range(0, 4)), -1, r);
            check("random_vec", r, partial(s, 16));
        end

        // Abort at BUSY cycle 8
        s        = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        state_in = s;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("pre_abort_busy", {busy, out_valid, in_ready}, 3'b100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_flags", {busy, out_valid, in_ready}, 3'b001);
        check("abort_work", state_out, 128'h0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);

        s = {$urandom, $urandom, $urandom, $urandom};
        run_op(s, 1, -1, r);
        check("after_abort", r, partial(s, 16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
